// File: rtl/hazard_scoreboard.sv
// Purpose : data-hazard scoreboard for the in-order pipeline; tracks in-flight destinations EX..WB
// Latency : stall/forward decision is combinational in the ID cycle; tracking state moves on the next edge
// Backpres: stall holds PC and if_id and puts one bubble into EX per stalled cycle; flush overrides stall
//
// Build option: HAZARD_FWD_EN
//   defined   -> forwarding from any tracked stage; stall only on a load-use hit in EX
//   undefined -> no forwarding; stall while any used source matches any tracked writer
//
// Ports:
//   clk, rst_n            pipeline clock (rising edge), asynchronous active-low reset
//   id_valid              ID stage holds a real instruction
//   id_src_a/b, id_use_a/b  source register addresses and whether each is read
//   id_dst, id_wr_en      destination register and whether it is written
//   id_is_load            instruction is a load (result ready only after MEM)
//   flush                 squash ID and every tracked stage
//   stall                 hold PC/if_id, bubble into id_ex
//   fwd_sel_a/b           0 = regfile, k = forward from tracked stage k-1
//   stall_cnt             saturating count of stalled cycles since reset

module hazard_scoreboard #(
    parameter  int REG_AW     = 5,
    parameter  int PIPE_DEPTH = 3,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // One tracked instruction per stage after ID.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] dst;
        logic              wr;
        logic              ld;
    } entry_t;

    entry_t                pipeEnt [PIPE_DEPTH];
    logic [CNT_W-1:0]      stallCnt;
    logic [PIPE_DEPTH-1:0] hitA;
    logic [PIPE_DEPTH-1:0] hitB;
    logic                  activeId;

    // A flushed or empty ID slot never stalls and never forwards.
    assign activeId = id_valid & ~flush;

    // Per-stage operand matches. r0 is hardwired zero, so it never matches.
    always_comb begin
        hitA = '0;
        hitB = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            hitA[k] = id_use_a && (id_src_a != '0) && pipeEnt[k].vld && pipeEnt[k].wr
                      && (pipeEnt[k].dst == id_src_a);
            hitB[k] = id_use_b && (id_src_b != '0) && pipeEnt[k].vld && pipeEnt[k].wr
                      && (pipeEnt[k].dst == id_src_b);
        end
    end

`ifdef HAZARD_FWD_EN
    logic loadUse;

    // Select of the youngest matching stage; scanning oldest to youngest lets the
    // lowest k win when several in-flight writers target the same register.
    function automatic logic [SEL_W-1:0] youngestSel(input logic [PIPE_DEPTH-1:0] hits);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (hits[k]) begin
                sel = SEL_W'(k + 1);
            end
        end
        return sel;
    endfunction

    // A load in EX has no data yet; anything older than EX can be forwarded,
    // including a load that has reached MEM or beyond.
    assign loadUse   = (hitA[0] | hitB[0]) & pipeEnt[0].ld;
    assign stall     = activeId & loadUse;
    assign fwd_sel_a = (activeId & ~loadUse) ? youngestSel(hitA) : '0;
    assign fwd_sel_b = (activeId & ~loadUse) ? youngestSel(hitB) : '0;
`else
    logic unusedLd;

    // Without forwarding every producer must retire before the consumer issues,
    // so a back-to-back dependency waits PIPE_DEPTH cycles.
    assign stall     = activeId & ((|hitA) | (|hitB));
    assign fwd_sel_a = '0;
    assign fwd_sel_b = '0;

    // The load flag is still tracked so both builds share one entry layout;
    // only the forwarding build consumes it.
    always_comb begin
        unusedLd = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            unusedLd = unusedLd ^ pipeEnt[k].ld;
        end
    end
`endif

    // Tracking shift register and stall counter. A stalled ID enters EX as a
    // bubble (vld=0), giving exactly one bubble per stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipeEnt[k] <= '0;
            end
            stallCnt <= '0;
        end else begin
            if (flush) begin
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    pipeEnt[k] <= '0;
                end
            end else begin
                pipeEnt[0] <= '{vld: id_valid & ~stall, dst: id_dst, wr: id_wr_en, ld: id_is_load};
                for (int k = 1; k < PIPE_DEPTH; k++) begin
                    pipeEnt[k] <= pipeEnt[k-1];
                end
            end
            // stall is already forced low under flush, so a flushed cycle never counts.
            if (stall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stallCnt;

endmodule
